msx_bus_host: RTL and testbench

MSX cartridge-bus initiator: turns single-word read/write requests into Z80-style memory or I/O bus cycles on the cartridge-slot signals, and drives the 3.579545 MHz bus clock. It drives what a cartridge core receives and samples what it returns: `ta`, `td`, strobes, `twait`. Used in the bench/host FPGA to exercise cartridge cores, and as the bus engine of a future host-side board. Runs on the 21.47727 MHz PLL clock; one T-state is 6 `clk`.

---
 rtl/msx_bus_pkg.sv | 23 ++
 rtl/msx_bus_host_if.sv | 38 +++
 rtl/msx_tstate_gen.sv | 33 +++
 rtl/msx_bus_host.sv | 134 +++++++++++++
 tb/tb_msx_bus_host.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/msx_bus_pkg.sv
// rtl/msx_bus_pkg.sv - shared types and constants for the MSX cartridge-bus host
// Contents: state_t bus-cycle states, T_PHASES clk per T-state, RDATA_ABORT read value
// returned on a wait timeout, in_strobe() for states that assert the bus strobes.
package msx_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    TW   = 3'd4,
    T3   = 3'd5
  } state_t;

  localparam int         T_PHASES    = 6;
  localparam logic [7:0] RDATA_ABORT = 8'hFF;

  // Strobes (MREQ/IORQ/SLTSL/RD/WR) are asserted from T2 to the end of T3.
  function automatic logic in_strobe(input state_t s);
    return (s == T2) || (s == TW) || (s == T3);
  endfunction

endpackage

// File: rtl/msx_bus_host_if.sv
// rtl/msx_bus_host_if.sv - request and cartridge-slot signal bundle
// Request side: req, ready, req_addr, req_wdata, req_write, req_io, ack, rdata, err.
// Slot side: tclock, ta, td_out, td_oe, td_in, n_tsltsl, n_tmerq, n_tiorq, n_trd,
// n_twr, twait. master = bus host, slave = requester plus cartridge.
interface msx_bus_host_if;
  logic        req;
  logic        ready;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_write;
  logic        req_io;
  logic        ack;
  logic [7:0]  rdata;
  logic        err;
  logic        tclock;
  logic [15:0] ta;
  logic [7:0]  td_out;
  logic        td_oe;
  logic [7:0]  td_in;
  logic        n_tsltsl;
  logic        n_tmerq;
  logic        n_tiorq;
  logic        n_trd;
  logic        n_twr;
  logic        twait;

  modport master (
    input  req, req_addr, req_wdata, req_write, req_io, td_in, twait,
    output ready, ack, rdata, err, tclock, ta, td_out, td_oe,
           n_tsltsl, n_tmerq, n_tiorq, n_trd, n_twr
  );

  modport slave (
    output req, req_addr, req_wdata, req_write, req_io, td_in, twait,
    input  ready, ack, rdata, err, tclock, ta, td_out, td_oe,
           n_tsltsl, n_tmerq, n_tiorq, n_trd, n_twr
  );
endinterface

// File: rtl/msx_tstate_gen.sv
// rtl/msx_tstate_gen.sv - free-running T-state phase counter and bus clock
// Ports: clk, n_reset (async, active low) in; tclock (registered bus clock, high
// for the first half of each T-state) and t_end (last clk of a T-state) out.
module msx_tstate_gen
  import msx_bus_pkg::*;
(
  input  logic clk,
  input  logic n_reset,
  output logic tclock,
  output logic t_end
);

  localparam logic [2:0] PH_LAST = 3'(T_PHASES - 1);
  localparam logic [2:0] PH_HALF = 3'(T_PHASES / 2);

  logic [2:0] ph;
  logic [2:0] ph_nxt;

  assign ph_nxt = (ph == PH_LAST) ? 3'd0 : ph + 3'd1;
  assign t_end  = (ph == PH_LAST);

  // tclock is decoded from the next phase so the pin comes straight off a flop.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ph     <= 3'd0;
      tclock <= 1'b1;
    end else begin
      ph     <= ph_nxt;
      tclock <= (ph_nxt < PH_HALF);
    end
  end

endmodule

// File: rtl/msx_bus_host.sv
// rtl/msx_bus_host.sv - MSX cartridge-bus initiator (memory and I/O cycles)
// Ports: clk, n_reset (async, active low); bus (msx_bus_host_if.master) carrying the
// single-word request handshake and the cartridge-slot address/data/strobe pins.
// Parameters: WAIT_LIMIT total TW states before abort, IO_WAIT_STATES mandatory I/O TWs.
module msx_bus_host
  import msx_bus_pkg::*;
#(
  parameter int WAIT_LIMIT     = 255,
  parameter int IO_WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           n_reset,
  msx_bus_host_if.master bus
);

  localparam logic [8:0] LIMIT_W   = 9'(WAIT_LIMIT);
  localparam logic [8:0] IO_WAIT_W = 9'(IO_WAIT_STATES);
  localparam logic       IO_HAS_TW = (IO_WAIT_STATES > 0);

  state_t      state;
  state_t      nxt;
  logic        abort;
  logic        abort_nxt;
  logic        t_end;
  logic [15:0] cap_addr;
  logic [7:0]  cap_wdata;
  logic        cap_write;
  logic        cap_io;
  logic [7:0]  tw_cnt;
  logic [8:0]  tw_inc;
  logic        wait_meta;
  logic        wait_s;

  msx_tstate_gen u_tstate (
    .clk     (clk),
    .n_reset (n_reset),
    .tclock  (bus.tclock),
    .t_end   (t_end)
  );

  // Nine bits so the TW count that would follow 255 still compares correctly.
  assign tw_inc = {1'b0, tw_cnt} + 9'd1;

  always_comb begin
    nxt       = state;
    abort_nxt = abort;
    case (state)
      IDLE: if (bus.req) nxt = ARM;
      ARM:  if (t_end) nxt = T1;
      T1:   if (t_end) nxt = T2;
      T2:   if (t_end) nxt = ((cap_io && IO_HAS_TW) || wait_s) ? TW : T3;
      TW: begin
        if (t_end) begin
          if (tw_inc == LIMIT_W) begin
            nxt       = T3;
            abort_nxt = 1'b1;
          end else if ((cap_io && (tw_inc < IO_WAIT_W)) || wait_s) begin
            nxt = TW;
          end else begin
            nxt = T3;
          end
        end
      end
      T3:      if (t_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Every pin is registered from the next state, so it follows the state change
  // in the same clk and the strobes are already released when ack pulses.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      abort        <= 1'b0;
      cap_addr     <= 16'h0000;
      cap_wdata    <= 8'h00;
      cap_write    <= 1'b0;
      cap_io       <= 1'b0;
      tw_cnt       <= 8'h00;
      wait_meta    <= 1'b0;
      wait_s       <= 1'b0;
      bus.ready    <= 1'b1;
      bus.ack      <= 1'b0;
      bus.rdata    <= 8'h00;
      bus.err      <= 1'b0;
      bus.ta       <= 16'h0000;
      bus.td_out   <= 8'h00;
      bus.td_oe    <= 1'b0;
      bus.n_tsltsl <= 1'b1;
      bus.n_tmerq  <= 1'b1;
      bus.n_tiorq  <= 1'b1;
      bus.n_trd    <= 1'b1;
      bus.n_twr    <= 1'b1;
    end else begin
      wait_meta <= bus.twait;
      wait_s    <= wait_meta;
      state     <= nxt;
      abort     <= abort_nxt;
      bus.ack   <= 1'b0;

      if (state == IDLE && bus.req) begin
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cap_write <= bus.req_write;
        cap_io    <= bus.req_io;
        tw_cnt    <= 8'h00;
        abort     <= 1'b0;
      end

      if (state == TW && t_end && tw_cnt != 8'hFF) tw_cnt <= tw_cnt + 8'd1;

      if (state == T3 && t_end) begin
        bus.ack <= 1'b1;
        bus.err <= abort;
        if (abort) bus.rdata <= RDATA_ABORT;
        else if (!cap_write) bus.rdata <= bus.td_in;
      end

      if (state == ARM && nxt == T1) begin
        bus.ta <= cap_addr;
        if (cap_write) bus.td_out <= cap_wdata;
      end

      bus.ready    <= (nxt == IDLE);
      bus.td_oe    <= cap_write && (nxt == T1 || in_strobe(nxt));
      bus.n_tsltsl <= !(in_strobe(nxt) && !cap_io);
      bus.n_tmerq  <= !(in_strobe(nxt) && !cap_io);
      bus.n_tiorq  <= !(in_strobe(nxt) && cap_io);
      bus.n_trd    <= !(in_strobe(nxt) && !cap_write);
      bus.n_twr    <= !(in_strobe(nxt) && cap_write);
    end
  end

endmodule

// File: tb/tb_msx_bus_host.sv
// tb/tb_msx_bus_host.sv - directed self-checking bench for msx_bus_host
// Two hosts share clk/reset: dut_i with default parameters, dut_t with WAIT_LIMIT=4.
module tb_msx_bus_host;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        wr = 1'b0;
  logic        io = 1'b0;
  logic [7:0]  tdin = 8'h00;
  logic        twait = 1'b0;

  always #5 clk = ~clk;

  msx_bus_host_if bi();
  msx_bus_host_if bt();

  msx_bus_host dut_i (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bi.master)
  );

  msx_bus_host #(.WAIT_LIMIT(4), .IO_WAIT_STATES(1)) dut_t (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bt.master)
  );

  assign bi.req = req & ~sel;
  assign bt.req = req & sel;
  assign bi.req_addr = addr;
  assign bt.req_addr = addr;
  assign bi.req_wdata = wdata;
  assign bt.req_wdata = wdata;
  assign bi.req_write = wr;
  assign bt.req_write = wr;
  assign bi.req_io = io;
  assign bt.req_io = io;
  assign bi.td_in = tdin;
  assign bt.td_in = tdin;
  assign bi.twait = twait;
  assign bt.twait = twait;

  // Strobe vector order: {sltsl, mreq, iorq, rd, wr}
  logic [4:0]  o_strb;
  logic        o_ack, o_err, o_ready, o_td_oe;
  logic [7:0]  o_rdata, o_td_out;
  logic [15:0] o_ta;
  assign o_strb   = sel ? {bt.n_tsltsl, bt.n_tmerq, bt.n_tiorq, bt.n_trd, bt.n_twr}
                        : {bi.n_tsltsl, bi.n_tmerq, bi.n_tiorq, bi.n_trd, bi.n_twr};
  assign o_ack    = sel ? bt.ack : bi.ack;
  assign o_err    = sel ? bt.err : bi.err;
  assign o_ready  = sel ? bt.ready : bi.ready;
  assign o_td_oe  = sel ? bt.td_oe : bi.td_oe;
  assign o_rdata  = sel ? bt.rdata : bi.rdata;
  assign o_td_out = sel ? bt.td_out : bi.td_out;
  assign o_ta     = sel ? bt.ta : bi.ta;

  // cyc mirrors the phase counter: at a negedge, phase = cyc % 6.
  int cyc;
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int n_ack_i = 0;
  always @(negedge clk) if (bi.ack) n_ack_i <= n_ack_i + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int r_lat, r_arm, r_slt, r_mrq, r_ior, r_rd, r_wr, r_oe;
  logic [7:0]  r_tdo, r_rdata;
  logic        r_err, r_ready, r_done;
  logic [4:0]  r_strb;
  logic [15:0] r_ta;

  // Issues one request at the current negedge and follows it to ack.
  // tw_from/poke_at are offsets from the end of ARM (-1 disables).
  task automatic xfer(input logic s, input logic [15:0] a, input logic [7:0] d,
                      input logic w, input logic i, input int tw_from, input int tw_len,
                      input int poke_at);
    int p0, lat;
    sel = s; addr = a; wdata = d; wr = w; io = i; req = 1'b1;
    p0 = cyc % 6;
    r_arm = (p0 == 5) ? 6 : 5 - p0;
    r_slt = 0; r_mrq = 0; r_ior = 0; r_rd = 0; r_wr = 0; r_oe = 0; r_tdo = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    while (!o_ack && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (tw_from >= 0 && lat == r_arm + tw_from) twait = 1'b1;
      if (tw_from >= 0 && lat == r_arm + tw_from + tw_len) twait = 1'b0;
      if (poke_at >= 0 && lat == r_arm + poke_at) begin req = 1'b1; addr = 16'hDEAD; end
      if (poke_at >= 0 && lat == r_arm + poke_at + 1) req = 1'b0;
      if (!o_strb[4]) r_slt++;
      if (!o_strb[3]) r_mrq++;
      if (!o_strb[2]) r_ior++;
      if (!o_strb[1]) r_rd++;
      if (!o_strb[0]) r_wr++;
      if (o_td_oe) begin r_oe++; r_tdo = o_td_out; end
    end
    r_lat = lat; r_done = o_ack; r_rdata = o_rdata; r_err = o_err;
    r_ready = o_ready; r_strb = o_strb; r_ta = o_ta;
  endtask

  initial begin : main
    logic [11:0] tc_obs, tc_exp;
    int n0, p0, arm, lat;

    repeat (3) @(negedge clk);
    check("rst_strobes", {27'd0, bi.n_tsltsl, bi.n_tmerq, bi.n_tiorq, bi.n_trd, bi.n_twr}, 32'h1F);
    check("rst_td_oe", {31'd0, bi.td_oe}, 32'd0);
    check("rst_ta", {16'd0, bi.ta}, 32'd0);
    check("rst_td_out", {24'd0, bi.td_out}, 32'd0);
    check("rst_rdata", {24'd0, bi.rdata}, 32'd0);
    check("rst_ack_err", {30'd0, bi.ack, bi.err}, 32'd0);
    check("rst_ready", {31'd0, bi.ready}, 32'd1);
    check("rst_tclock", {31'd0, bi.tclock}, 32'd1);
    n_reset = 1'b1;

    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      tc_obs[k] = bi.tclock;
      tc_exp[k] = ((cyc % 6) < 3);
    end
    check("tclock_pattern", {20'd0, tc_obs}, {20'd0, tc_exp});

    // Memory read, then an I/O write requested in the ack clk.
    tdin = 8'h5A;
    xfer(1'b0, 16'h4000, 8'h00, 1'b0, 1'b0, -1, 0, -1);
    check("mrd_done", {31'd0, r_done}, 32'd1);
    check("mrd_latency", r_lat, r_arm + 18);
    check("mrd_sltsl_lo", r_slt, 12);
    check("mrd_mreq_lo", r_mrq, 12);
    check("mrd_rd_lo", r_rd, 12);
    check("mrd_iorq_wr_oe", r_ior + r_wr + r_oe, 0);
    check("mrd_rdata", {24'd0, r_rdata}, 32'h5A);
    check("mrd_err", {31'd0, r_err}, 32'd0);
    check("mrd_ready_at_ack", {31'd0, r_ready}, 32'd1);
    check("mrd_strobes_at_ack", {27'd0, r_strb}, 32'h1F);
    check("mrd_ta", {16'd0, r_ta}, 32'h4000);

    xfer(1'b0, 16'h00A0, 8'h3C, 1'b1, 1'b1, -1, 0, -1);
    check("iow_done", {31'd0, r_done}, 32'd1);
    check("iow_b2b_latency", r_lat, r_arm + 24);
    check("iow_iorq_lo", r_ior, 18);
    check("iow_wr_lo", r_wr, 18);
    check("iow_mem_rd_lo", r_slt + r_mrq + r_rd, 0);
    check("iow_oe_hi", r_oe, 24);
    check("iow_td_out", {24'd0, r_tdo}, 32'h3C);
    check("iow_rdata_kept", {24'd0, r_rdata}, 32'h5A);
    check("iow_ta", {16'd0, r_ta}, 32'h00A0);

    // Cartridge wait: twait high 20 clk across the T2 end gives three TW states.
    repeat (3) @(negedge clk);
    tdin = 8'hA5;
    xfer(1'b0, 16'h4123, 8'h00, 1'b0, 1'b0, 4, 20, -1);
    check("wait_latency", r_lat, r_arm + 36);
    check("wait_mreq_lo", r_mrq, 30);
    check("wait_rdata", {24'd0, r_rdata}, 32'hA5);
    check("wait_err", {31'd0, r_err}, 32'd0);

    // Timeout with WAIT_LIMIT=4: four TW states then abort.
    repeat (3) @(negedge clk);
    twait = 1'b1;
    tdin = 8'h12;
    xfer(1'b1, 16'h4000, 8'h00, 1'b0, 1'b0, -1, 0, -1);
    twait = 1'b0;
    check("tmo_latency", r_lat, r_arm + 42);
    check("tmo_mreq_lo", r_mrq, 36);
    check("tmo_err", {31'd0, r_err}, 32'd1);
    check("tmo_rdata", {24'd0, r_rdata}, 32'hFF);

    // Request while busy is ignored.
    repeat (3) @(negedge clk);
    tdin = 8'h77;
    n0 = n_ack_i;
    xfer(1'b0, 16'h8000, 8'h00, 1'b0, 1'b0, -1, 0, 8);
    check("busy_latency", r_lat, r_arm + 18);
    check("busy_ta", {16'd0, r_ta}, 32'h8000);
    check("busy_rdata", {24'd0, r_rdata}, 32'h77);
    @(negedge clk);
    check("ack_one_clk", {31'd0, bi.ack}, 32'd0);
    repeat (30) @(negedge clk);
    check("busy_ack_count", n_ack_i - n0, 1);

    // Reset in the middle of an I/O write's TW state.
    sel = 1'b0; addr = 16'h00A0; wdata = 8'h99; wr = 1'b1; io = 1'b1; twait = 1'b1;
    req = 1'b1;
    p0 = cyc % 6;
    arm = (p0 == 5) ? 6 : 5 - p0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    while (lat < arm + 14) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("mid_strobes_tw", {27'd0, bi.n_tsltsl, bi.n_tmerq, bi.n_tiorq, bi.n_trd, bi.n_twr}, 32'h1A);
    check("mid_td_oe_tw", {31'd0, bi.td_oe}, 32'd1);
    n0 = n_ack_i;
    n_reset = 1'b0;
    #1;
    check("mid_rst_strobes", {27'd0, bi.n_tsltsl, bi.n_tmerq, bi.n_tiorq, bi.n_trd, bi.n_twr}, 32'h1F);
    check("mid_rst_td_oe", {31'd0, bi.td_oe}, 32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    twait = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_no_ack", n_ack_i - n0, 0);
    check("mid_ready", {31'd0, bi.ready}, 32'd1);
    check("mid_strobes_after", {27'd0, bi.n_tsltsl, bi.n_tmerq, bi.n_tiorq, bi.n_trd, bi.n_twr}, 32'h1F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
